// File: rtl/rle_pkg.sv
// Shared RLE datapath definitions: default widths, decoder state encoding, maximum run count.
package rle_pkg;

    localparam int RLE_DATA_W  = 32;
    localparam int RLE_COUNT_W = 8;
    localparam int COUNT_MAX   = (1 << RLE_COUNT_W) - 1;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } dec_state_e;

endpackage

// File: rtl/rle_run_counter.sv
// Remaining-beats down-counter for one run; load wins over dec, and the counter never underflows.
module rle_run_counter #(
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic               dec_i,
    input  logic [COUNT_W-1:0] value_i,
    output logic               zero_o
);

    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - COUNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (word, count-1) pairs into repeated words at one word per clock.
// Optional out_last marker on the final word of each run is enabled by RLE_DEC_OUT_LAST_EN.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int DATA_W  = RLE_DATA_W,
    parameter int COUNT_W = RLE_COUNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [COUNT_W-1:0] in_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy
`ifdef RLE_DEC_OUT_LAST_EN
    ,
    output logic               out_last
`endif
);

    // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and held data stays stable until taken.
    dec_state_e        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              accept;
    logic              beat;
    logic              run_zero;

    assign out_valid = (state_q == EXPAND);
    assign busy      = out_valid;
    assign out_data  = hold_q;
    assign beat      = out_valid && out_ready;
    // Accepting on the final beat of a run is what keeps pair boundaries bubble-free.
    assign in_ready  = !reset && ((state_q == IDLE) || (beat && run_zero));
    assign accept    = in_valid && in_ready;

`ifdef RLE_DEC_OUT_LAST_EN
    assign out_last  = out_valid && run_zero;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = EXPAND;
            end
            EXPAND: begin
                if (beat && run_zero && !accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) hold_d = in_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    rle_run_counter #(
        .COUNT_W (COUNT_W)
    ) u_run_counter (
        .clock   (clock),
        .reset   (reset),
        .load_i  (accept),
        .dec_i   (beat && !run_zero),
        .value_i (in_count),
        .zero_o  (run_zero)
    );

endmodule

// File: tb/tb_rle_decoder.sv
// Bench for rle_decoder: directed vector table, directed corner sequences, randomized traffic vs a queue model.
module tb_rle_decoder;
    import rle_pkg::*;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_count = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          busy;
`ifdef RLE_DEC_OUT_LAST_EN
    logic          out_last;
`endif

    always #5 clock = ~clock;

    rle_decoder #(
        .DATA_W  (DW),
        .COUNT_W (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef RLE_DEC_OUT_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          ev;
        logic          er;
        logic [DW-1:0] ed;
        logic          el;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the expected output word stream; a pair of count c adds c+1 copies.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
        logic ev;
        logic er;
        in_valid  = v;
        in_data   = d;
        in_count  = c;
        out_ready = ordy;
        @(negedge clock);
        ev = (exp_q.size() > 0);
        er = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
        chk("out_valid", out_valid, ev);
        chk("busy", busy, ev);
        chk("in_ready", in_ready, er);
        if (ev) chk("out_data", out_data, exp_q[0]);
`ifdef RLE_DEC_OUT_LAST_EN
        chk("out_last", out_last, ev && exp_q.size() == 1);
`endif
        if (out_valid && ordy) beats++;
        if (ev && ordy) void'(exp_q.pop_front());
        if (v && er) begin
            for (int i = 0; i <= int'(c); i++) exp_q.push_back(d);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // single pair FFFFFFFF x4
        tbl[0]  = '{1'b1, 32'hFFFFFFFF, 8'd3, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h0,        8'd0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,        8'd0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,        8'd0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        8'd0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1};
        tbl[5]  = '{1'b0, 32'h0,        8'd0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0};
        // back-to-back (AAAAAAAA,1) then (00000000,0)
        tbl[6]  = '{1'b1, 32'hAAAAAAAA, 8'd1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 32'h00000000, 8'd0, 1'b1, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b0};
        tbl[8]  = '{1'b1, 32'h00000000, 8'd0, 1'b1, 1'b1, 1'b1, 32'hAAAAAAAA, 1'b1};
        tbl[9]  = '{1'b0, 32'h0,        8'd0, 1'b1, 1'b1, 1'b1, 32'h00000000, 1'b1};
        tbl[10] = '{1'b0, 32'h0,        8'd0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0};
        // backpressure: count 2, out_ready 1,0,0,1,0,1; junk pairs offered while not ready
        tbl[11] = '{1'b1, 32'h5A5A5A5A, 8'd2, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0};
        tbl[12] = '{1'b1, 32'hDEADBEEF, 8'd7, 1'b1, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b0};
        tbl[13] = '{1'b1, 32'hDEADBEEF, 8'd7, 1'b0, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b0};
        tbl[14] = '{1'b1, 32'hDEADBEEF, 8'd7, 1'b0, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b0};
        tbl[15] = '{1'b1, 32'hDEADBEEF, 8'd7, 1'b1, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b0};
        tbl[16] = '{1'b1, 32'hDEADBEEF, 8'd7, 1'b0, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b1};
        tbl[17] = '{1'b0, 32'h0,        8'd0, 1'b1, 1'b1, 1'b1, 32'h5A5A5A5A, 1'b1};
        tbl[18] = '{1'b0, 32'h0,        8'd0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0};

        // reset values while reset is held
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_data", out_data, '0);
`ifdef RLE_DEC_OUT_LAST_EN
        chk("rst_out_last", out_last, 1'b0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;

        // directed vector table
        for (int i = 0; i < 19; i++) begin
            in_valid  = tbl[i].v;
            in_data   = tbl[i].d;
            in_count  = tbl[i].c;
            out_ready = tbl[i].ordy;
            @(negedge clock);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ev);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].er);
            if (tbl[i].ev) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].ed);
`ifdef RLE_DEC_OUT_LAST_EN
            chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].el);
`endif
            @(posedge clock);
            #1;
        end

        // maximum run: 256 beats, then a following pair is still accepted
        beats = 0;
        step(1'b1, 32'hA0A0A0A0, CW'(COUNT_MAX), 1'b1);
        for (int n = 0; n < 300 && exp_q.size() > 0; n++) step(1'b0, $urandom, CW'($urandom), 1'b1);
        chk("maxrun_drained", DW'(exp_q.size()), '0);
        chk("maxrun_beats", DW'(beats), DW'(256));
        step(1'b1, 32'h0000_0011, 8'd0, 1'b1);
        step(1'b0, 32'h0, 8'd0, 1'b1);
        step(1'b0, 32'h0, 8'd0, 1'b1);

        // reset during beat 2 of a count=5 run
        step(1'b1, 32'hCAFEF00D, 8'd5, 1'b1);
        step(1'b0, 32'h0, 8'd0, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_data", out_data, '0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        beats = 0;
        step(1'b1, 32'h12345678, 8'd0, 1'b1);
        step(1'b0, 32'h0, 8'd0, 1'b1);
        step(1'b0, 32'h0, 8'd0, 1'b1);
        chk("midrst_beats", DW'(beats), DW'(1));

        // randomized traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            logic          v;
            logic          r;
            logic [CW-1:0] c;
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 19) == 0) ? CW'($urandom_range(0, 255)) : CW'($urandom_range(0, 6));
            step(v, $urandom, c, r);
        end
        for (int n = 0; n < 400 && exp_q.size() > 0; n++) step(1'b0, $urandom, CW'($urandom), 1'b1);
        chk("random_drained", DW'(exp_q.size()), '0);
        step(1'b0, 32'h0, 8'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rle_decoder.md
# rle_decoder

Run-length decoder for the RLE datapath: accepts (word, run count) pairs produced by the RLE encoder and re-expands each pair into a stream of repeated 32-bit words. It sits at the receive end of the RLE link, between the pair FIFO and the downstream word consumer. A valid/ready handshake is used on both sides, and back-to-back pairs are sustained at one word per clock.

## Interface
- DATA_W, default 32: width of the data word.
- COUNT_W, default 8: width of the run-count field. This matches the encoder's run counter, whose overflow closes a run.

- clock, input, 1: the single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high. It clears all state immediately; release is synchronous to clock.
- in_valid, input, 1: a pair is presented on in_data/in_count.
- in_ready, output, 1: the decoder accepts the pair this cycle.
- in_data, input, DATA_W: the word to repeat.
- in_count, input, COUNT_W: run length minus one.
- out_valid, output, 1: out_data holds a valid word.
- out_ready, input, 1: the consumer takes out_data this cycle.
- out_data, output, DATA_W: the expanded word.
- busy, output, 1: a run is in progress (state EXPAND).

## Operation
- Count encoding: in_count = N−1 means N output words.
  - 0 gives 1 word.
  - 2^COUNT_W−1 gives 2^COUNT_W words.
  - A zero-length run does not exist.
- Pair accept: in_valid && in_ready at a rising edge.
  - Latches in_data into the hold register.
  - Loads the remain counter with in_count.
- Output beat: out_valid && out_ready at a rising edge.
  - If remain != 0, decrement remain.
  - If remain == 0, the run ends.
- FSM, 2 states:
  - IDLE: out_valid=0, in_ready=1. On accept, go to EXPAND.
  - EXPAND: out_valid=1, out_data=hold.
    - Final beat with in_valid high: accept the next pair in the same cycle and stay in EXPAND.
    - Final beat with in_valid low: go to IDLE.
    - Any other beat: stay in EXPAND.
- in_ready = !reset && (state==IDLE || (state==EXPAND && out_ready && remain==0)).
  - This is a combinational path from out_ready to in_ready, and it is permitted.
- out_valid stays asserted and out_data stays stable while out_ready is low. No beat is dropped or duplicated.
- in_data and in_count are sampled only on accept. They are ignored at all other times.

## Timing
- Reset values:
  - state=IDLE, remain=0, hold=0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after release.
- Latency: a pair accepted at edge k makes out_valid=1 after edge k, with the first word available at edge k+1.
- Throughput: 1 word per clock with out_ready held high, including across pair boundaries (no bubble).
- Run duration: a pair with count c occupies exactly c+1 accepted output beats.
- Reset mid-run: the run is abandoned, out_valid falls asynchronously, and no partial state survives.
- Max run: remain never underflows. The value 2^COUNT_W−1 counts down to 0.

## Configuration
- RLE_DEC_OUT_LAST_EN defined:
  - Adds output out_last, 1 bit.
  - out_last = out_valid && remain==0, marking the final word of each run.
  - Reset value is 0.
- RLE_DEC_OUT_LAST_EN undefined: there is no out_last port and no related logic. All other behaviour is identical.

## Structure
- Package rle_pkg holds:
  - The DATA_W and COUNT_W defaults, shared with the encoder.
  - The decoder state enum (IDLE, EXPAND).
  - The localparam COUNT_MAX = 2^COUNT_W−1.
- Sub-module rle_run_counter: COUNT_W down-counter with these controls:
  - load: takes priority over dec.
  - dec.
  - Output zero flag.
- The FSM and hold register live in rle_decoder.

## Test plan
- Single pair: data=0xFFFFFFFF, count=3, out_ready=1 → exactly 4 beats of 0xFFFFFFFF on consecutive cycles, then out_valid=0 and busy=0.
- Back-to-back: pairs (0xAAAAAAAA, 1) then (0x00000000, 0) presented continuously → beats AAAAAAAA, AAAAAAAA, 00000000 with no idle cycle. in_ready is high on the final AAAAAAAA beat.
- Backpressure: count=2 with out_ready toggling 1,0,0,1,0,1 → out_data is held stable while stalled, exactly 3 beats total, and in_ready stays low until the last beat.
- Max run: count=255 (COUNT_W=8), data=0xA0A0A0A0 → exactly 256 beats, no wrap, and the next pair is accepted afterwards.
- Reset mid-run: assert reset during beat 2 of a count=5 run → out_valid=0 and busy=0 immediately. After release, a fresh (0x12345678, 0) yields exactly one beat.
- With RLE_DEC_OUT_LAST_EN: count=2 → out_last=0, 0, 1 across the three beats. With count=0, out_last=1 on the single beat.
